writeback_control: RTL and testbench
====================================

# writeback_control

Sequencer for the register-file write port of the RV32 core. It accepts one instruction per cycle from execute and stalls the front end while a load or store waits on the data bus. It selects the write-back source and drives one registered register-file write per committed instruction. It also flags data-bus timeouts.

## Interface
Parameters:
- TIMEOUT, 16, max cycles mem_req stays high without mem_ack before abort (≥2)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  execute presents an instruction this cycle
- rd  in  5  destination register index
- reg_write  in  1  instruction writes rd
- mem_read  in  1  load
- mem_write  in  1  store
- mem_to_reg  in  1  result comes from memory
- load_byte  in  1  load is byte-wide, zero-extended
- read_pc_4  in  1  result is pc+4 (JAL/JALR)
- alu_value  in  32  ALU result / memory address
- pc_4_value  in  32  pc+4
- store_data  in  32  store data
- mem_ack  in  1  data bus completes the request
- mem_rdata  in  32  load data, valid with mem_ack
- stall  out  1  hold fetch/decode/execute
- mem_req, mem_ren, mem_wen  out  1 each  bus request and direction
- mem_addr, mem_wdata  out  32 each  bus address and store data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write index
- rf_wdata  out  32  register-file write data
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, MEM_WAIT.
- **IDLE, instr_valid, no memory op:**
  - Registered write next cycle.
  - rf_we = reg_write & (rd≠0).
  - rf_wdata = pc_4_value if read_pc_4, else alu_value.
- **IDLE, instr_valid with mem_read|mem_write:**
  - Latch rd, reg_write, mem_to_reg, load_byte, read_pc_4, alu_value→mem_addr, store_data→mem_wdata, mem_read→mem_ren, mem_write→mem_wen.
  - Go to MEM_WAIT.
  - rf_we = 0 next cycle.
- **MEM_WAIT:**
  - mem_req = 1; mem_ren, mem_wen, mem_addr, mem_wdata held stable.
  - On mem_ack, return to IDLE.
  - If latched reg_write & rd≠0 & mem_read, the next cycle carries rf_we = 1.
- **rf_wdata priority** (same as the datapath): read_pc_4 → pc_4_value; else !mem_to_reg → latched alu_value; else load_byte → {24'b0, mem_rdata[7:0]}; else mem_rdata.
- Store, or any write with rd = 0: rf_we stays 0.
- **Timeout:**
  - A counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, go to IDLE and set bus_err (sticky until rst).
  - No register write on abort.
  - An ack in that final cycle wins: normal completion, no error.
- **stall** is combinational: (IDLE & instr_valid & (mem_read|mem_write)) | MEM_WAIT, including the ack cycle.
- mem_read & mem_write both set: treated as a load; mem_wen = 0.
- mem_ack outside MEM_WAIT: ignored.
- Inputs ignored when instr_valid = 0.

## Timing
- **Reset values:** IDLE; stall, mem_req, mem_ren, mem_wen, rf_we, bus_err = 0; mem_addr, mem_wdata, rf_waddr, rf_wdata = 0; timeout counter = 0.
- **Reset mid-MEM_WAIT:** abort with no write. Bus sees mem_req = 0 the cycle after rst.
- Non-memory instruction accepted in cycle N: rf_we high in N+1 only. Back-to-back acceptance every cycle.
- **Memory op accepted in N:**
  - mem_req high from N+1.
  - Ack in cycle A ≥ N+1: mem_req drops at A+1, load write at A+1, stall low at A+1, next instruction accepted at A+1 (its write lands at A+2).
  - At most one rf_we per cycle; minimum load latency 2 cycles (accept → write).
- **Timeout:** mem_req high exactly TIMEOUT cycles (N+1 … N+TIMEOUT). bus_err and IDLE from N+TIMEOUT+1.

## Test plan
- **ALU and pc+4 writes:** three back-to-back valid instrs:
  - ALU rd=5 alu=32'hEEEEEEEE → rf_we at N+1, x5 = EEEEEEEE.
  - read_pc_4 rd=1 pc_4=32'hDDDDDDDD → x1 = DDDDDDDD.
  - ALU rd=0 → rf_we = 0.
  - stall never high.
- **Word and byte loads, ack delay 3:**
  - mem_read, mem_to_reg, rd=7, addr 32'h100, mem_rdata 32'hFFFFFFFF.
  - mem_req high N+1..N+3, ack at N+3, stall high N..N+3.
  - rf_we at N+4, x7 = FFFFFFFF.
  - Repeat with load_byte=1 → x7 = 32'h000000FF.
- **Store, immediate ack:** store addr 32'h200 data 32'hA5A5A5A5 → mem_wen = 1, mem_req one cycle (N+1), rf_we never high, next instr accepted N+2.
- **Timeout, TIMEOUT=4, no ack:**
  - mem_req high exactly 4 cycles.
  - bus_err = 1 from N+5, stays set through later instrs.
  - No rf_we; a following ALU instr writes normally.
  - Repeat with ack in the 4th cycle → no error, write occurs.
- **Reset mid-load:** rst at the 2nd MEM_WAIT cycle → next cycle all outputs at reset values, no rf_we. A late mem_ack is ignored.

Source files
------------

// File: rtl/writeback_control.sv
// writeback_control: register-file write-back sequencer with load/store bus handshake and timeout abort
module writeback_control #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        load_byte,
    input  logic        read_pc_4,
    input  logic [31:0] alu_value,
    input  logic [31:0] pc_4_value,
    input  logic [31:0] store_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic {IDLE, MEM_WAIT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0] rd_q;
    logic reg_write_q, mem_to_reg_q, load_byte_q, read_pc_4_q;
    logic accept_mem, waiting, timeout, we_n;
    logic [4:0] waddr_n;
    logic [31:0] wdata_n, mem_result;
    assign waiting = state == MEM_WAIT;
    assign accept_mem = state == IDLE && instr_valid && (mem_read || mem_write);
    assign timeout = waiting && !mem_ack && cnt == CW'(TIMEOUT - 1);
    assign stall = accept_mem || waiting;
    assign mem_req = waiting;
    assign mem_result = read_pc_4_q ? pc_4_value : !mem_to_reg_q ? mem_addr :
                        load_byte_q ? {24'b0, mem_rdata[7:0]} : mem_rdata;
    always_comb begin
        state_n = state;
        we_n = 1'b0;
        waddr_n = rd;
        wdata_n = read_pc_4 ? pc_4_value : alu_value;
        if (waiting) begin
            state_n = (mem_ack || timeout) ? IDLE : MEM_WAIT;
            we_n = mem_ack && reg_write_q && rd_q != 5'd0 && mem_ren;
            waddr_n = rd_q;
            wdata_n = mem_result;
        end else begin
            state_n = accept_mem ? MEM_WAIT : IDLE;
            we_n = instr_valid && !mem_read && !mem_write && reg_write && rd != 5'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rd_q <= '0;
            reg_write_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            load_byte_q <= 1'b0;
            read_pc_4_q <= 1'b0;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= accept_mem ? '0 : (waiting && !mem_ack) ? cnt + 1'b1 : cnt;
            bus_err <= bus_err || timeout;
            rf_we <= we_n;
            if (we_n) begin
                rf_waddr <= waddr_n;
                rf_wdata <= wdata_n;
            end
            // a simultaneous read+write request is executed as a load
            if (accept_mem) begin
                rd_q <= rd;
                reg_write_q <= reg_write;
                mem_to_reg_q <= mem_to_reg;
                load_byte_q <= load_byte;
                read_pc_4_q <= read_pc_4;
                mem_addr <= alu_value;
                mem_wdata <= store_data;
                mem_ren <= mem_read;
                mem_wen <= mem_write && !mem_read;
            end
        end
    end
endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: vector table for ALU writes, hand sequences for bus ops, cycle-stamped write-back scoreboard
module tb_writeback_control;
    localparam int TIMEOUT = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic instr_valid = 1'b0, reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic mem_to_reg = 1'b0, load_byte = 1'b0, read_pc_4 = 1'b0, mem_ack = 1'b0;
    logic [4:0] rd = '0;
    logic [31:0] alu_value = '0, pc_4_value = '0, store_data = '0, mem_rdata = '0;
    logic stall, mem_req, mem_ren, mem_wen, rf_we, bus_err;
    logic [31:0] mem_addr, mem_wdata, rf_wdata;
    logic [4:0] rf_waddr;

    writeback_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .load_byte(load_byte), .read_pc_4(read_pc_4), .alu_value(alu_value),
        .pc_4_value(pc_4_value), .store_data(store_data), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .mem_req(mem_req), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;
    typedef struct {
        logic        rw;
        logic        rp4;
        logic [4:0]  d;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        we;
        logic [31:0] wd;
    } vec_t;

    wb_t q[$];
    vec_t tv[5];
    int cyc = 0, checks = 0, errors = 0;
    logic exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // every rf_we must match the oldest pending write in both data and due cycle
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL wb_missed: got no write, expected x%0d=%h at cycle %0d", q[0].a, q[0].d, q[0].cyc);
            void'(q.pop_front());
        end
        if (rf_we) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL wb_spurious: got x%0d=%h at cycle %0d, expected no write", rf_waddr, rf_wdata, cyc);
            end else begin
                chk32("wb_addr", {27'b0, rf_waddr}, {27'b0, q[0].a});
                chk32("wb_data", rf_wdata, q[0].d);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_ren", mem_ren, 1'b0);
        chk1("rst_wen", mem_wen, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_addr", mem_addr, 32'h0);
        chk32("rst_wdata", mem_wdata, 32'h0);
        chk32("rst_waddr", {27'b0, rf_waddr}, 32'h0);
        chk32("rst_rf_wdata", rf_wdata, 32'h0);
    endtask

    task automatic alu_op(input logic rw, input logic rp4, input logic [4:0] d,
                          input logic [31:0] alu, input logic [31:0] pc4);
        instr_valid = 1'b1; reg_write = rw; read_pc_4 = rp4; rd = d;
        alu_value = alu; pc_4_value = pc4; mem_read = 1'b0; mem_write = 1'b0;
        if (rw && d != 5'd0) q.push_back('{cyc + 1, d, rp4 ? pc4 : alu});
        @(negedge clk);
        chk1("alu_stall", stall, 1'b0);
        chk1("alu_req", mem_req, 1'b0);
        chk1("alu_bus_err", bus_err, exp_err);
        tick();
        instr_valid = 1'b0;
    endtask

    // dly = MEM_WAIT cycle carrying the ack (1 = immediate), 0 = never ack
    task automatic mem_op(input logic rdq, input logic wrq, input logic tr, input logic lb,
                          input logic [4:0] d, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int dly);
        int n;
        logic [31:0] w;
        n = dly != 0 ? dly : TIMEOUT;
        w = !tr ? a : lb ? {24'b0, rdat[7:0]} : rdat;
        instr_valid = 1'b1; reg_write = 1'b1; mem_read = rdq; mem_write = wrq;
        mem_to_reg = tr; load_byte = lb; read_pc_4 = 1'b0; rd = d;
        alu_value = a; store_data = sd; mem_ack = 1'b0;
        @(negedge clk);
        chk1("accept_stall", stall, 1'b1);
        chk1("accept_req", mem_req, 1'b0);
        tick();
        instr_valid = 1'b0; alu_value = ~a; store_data = ~sd; rd = ~d;
        mem_to_reg = ~tr; load_byte = ~lb; mem_read = ~rdq; mem_write = ~wrq;
        for (int k = 1; k <= n; k++) begin
            mem_ack = k == dly;
            mem_rdata = k == dly ? rdat : 32'hDEADBEEF;
            if (k == dly && rdq && d != 5'd0) q.push_back('{cyc + 1, d, w});
            @(negedge clk);
            chk1("wait_req", mem_req, 1'b1);
            chk1("wait_stall", stall, 1'b1);
            chk1("wait_ren", mem_ren, rdq);
            chk1("wait_wen", mem_wen, wrq && !rdq);
            chk32("wait_addr", mem_addr, a);
            chk32("wait_wdata", mem_wdata, sd);
            chk1("wait_bus_err", bus_err, exp_err);
            tick();
        end
        mem_ack = 1'b0;
        if (dly == 0) exp_err = 1'b1;
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 5'd5,  32'hEEEEEEEE, 32'h00000000, 1'b1, 32'hEEEEEEEE};
        tv[1] = '{1'b1, 1'b1, 5'd1,  32'h12345678, 32'hDDDDDDDD, 1'b1, 32'hDDDDDDDD};
        tv[2] = '{1'b1, 1'b0, 5'd0,  32'hFFFF0000, 32'h00000004, 1'b0, 32'h0};
        tv[3] = '{1'b0, 1'b0, 5'd9,  32'h0BADF00D, 32'h00000008, 1'b0, 32'h0};
        tv[4] = '{1'b1, 1'b0, 5'd31, 32'h00000001, 32'h0000000C, 1'b1, 32'h00000001};

        tick(); tick();
        @(negedge clk);
        chk_reset();
        tick();
        rst = 1'b0;

        // back-to-back ALU/pc+4 writes; a stray ack in IDLE must be ignored
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; reg_write = tv[i].rw; read_pc_4 = tv[i].rp4; rd = tv[i].d;
            alu_value = tv[i].alu; pc_4_value = tv[i].pc4; mem_read = 1'b0; mem_write = 1'b0;
            if (tv[i].we) q.push_back('{cyc + 1, tv[i].d, tv[i].wd});
            @(negedge clk);
            chk1("vec_stall", stall, 1'b0);
            chk1("vec_req", mem_req, 1'b0);
            tick();
        end
        instr_valid = 1'b0; mem_ack = 1'b0; pc_4_value = '0;
        tick();

        mem_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0, 32'hFFFFFFFF, 3);
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 32'hFFFFFFFF, 3);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h200, 32'hA5A5A5A5, 32'h0, 1);
        alu_op(1'b1, 1'b0, 5'd2, 32'h22222222, 32'h0);
        mem_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h444, 32'h0, 32'h99999999, 2);
        mem_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h300, 32'h0, 32'h77777777, 1);
        mem_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h304, 32'h55555555, 32'h13579BDF, 1);
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h308, 32'h0, 32'h0000815A, TIMEOUT);
        alu_op(1'b1, 1'b0, 5'd3, 32'h33333333, 32'h0);
        mem_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd11, 32'h30C, 32'h0, 32'h11111111, 0);
        alu_op(1'b1, 1'b0, 5'd12, 32'hC0C0C0C0, 32'h0);
        alu_op(1'b1, 1'b1, 5'd13, 32'h0, 32'h00001234);

        // reset during the second MEM_WAIT cycle, then a late ack
        instr_valid = 1'b1; reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        mem_to_reg = 1'b1; load_byte = 1'b0; rd = 5'd14; alu_value = 32'h400;
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk1("rstmid_req", mem_req, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hEEEE0000;
        exp_err = 1'b0;
        @(negedge clk);
        chk_reset();
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk1("late_ack_req", mem_req, 1'b0);
        tick();
        alu_op(1'b1, 1'b0, 5'd15, 32'hF0F0F0F0, 32'h0);

        tick(); tick();
        chk32("sb_drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
